fifo_word_serializer: RTL and testbench

//  Drain stage directly downstream of rbFIFO. Pops one MSBD+1-bit word at a time

---
 rtl/fifo_word_serializer_if.sv | 25 ++
 rtl/fifo_word_serializer.sv | 87 ++++++++
 tb/tb_fifo_word_serializer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_serializer_if.sv
// Signal bundle between the serializer, the rbFIFO show-ahead read port and the beat sink.
// master = serializer side, slave = FIFO + sink side.
interface fifo_word_serializer_if #(
  parameter int MSBD  = 63,
  parameter int OUT_W = 16
);
  logic [MSBD:0]    fifo_data;
  logic             fifo_empty;
  logic             fifo_push_acc;
  logic             fifo_pop;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    input  fifo_data, fifo_empty, fifo_push_acc, out_ready,
    output fifo_pop, out_data, out_valid, out_last
  );

  modport slave (
    output fifo_data, fifo_empty, fifo_push_acc, out_ready,
    input  fifo_pop, out_data, out_valid, out_last
  );
endinterface

// File: rtl/fifo_word_serializer.sv
// Pops whole words from rbFIFO's show-ahead port and streams them out as BEATS narrow beats,
// reloading on the last-beat handshake so consecutive words run without a bubble.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | no word held; pops as soon as the FIFO has a word
// ST_HOLD | word held in sreg, beat bidx presented on the stream
module fifo_word_serializer #(
  parameter int MSBD      = 63,
  parameter int OUT_W     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clock,
  input  logic                  rst,
  fifo_word_serializer_if.master bus,
  output logic [15:0]           words_sent
);
  localparam int BEATS = (MSBD + 1) / OUT_W;
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t           state_q, state_d;
  logic [MSBD:0]    sreg_q, sreg_d;
  logic [BW-1:0]    bidx_q, bidx_d;
  logic [15:0]      words_q, words_d;
  logic             acc;
  logic             last_beat;
  logic             can_load;
  logic             pop;
  logic [OUT_W-1:0] beat;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      bidx_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bidx_q  <= bidx_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bidx_d    = bidx_q;
    words_d   = words_q;
    last_beat = (state_q == ST_HOLD) && (bidx_q == LAST_IDX);
    acc       = (state_q == ST_HOLD) && bus.out_ready;
    can_load  = (state_q == ST_IDLE) || (acc && last_beat);
    // rbFIFO drops a pop that coincides with an accepted push, so defer to the next cycle
    pop       = !rst && can_load && !bus.fifo_empty && !bus.fifo_push_acc;

    if (acc && last_beat) words_d = words_q + 16'd1;

    if (pop) begin
      sreg_d  = bus.fifo_data;
      bidx_d  = '0;
      state_d = ST_HOLD;
    end else if (acc && last_beat) begin
      bidx_d  = '0;
      state_d = ST_IDLE;
    end else if (acc) begin
      bidx_d  = bidx_q + 1'b1;
    end
  end

  always_comb begin
    beat = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (bidx_q == BW'(b)) begin
        beat = MSB_FIRST ? sreg_q[MSBD - b*OUT_W -: OUT_W] : sreg_q[b*OUT_W +: OUT_W];
      end
    end
  end

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_last  = last_beat;
  assign bus.out_data  = beat;
  assign words_sent    = words_q;
endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: queue-based rbFIFO model feeding the DUT, beat scoreboard
// filled when words enter the FIFO and drained by a negedge monitor on each accepted beat.
module tb_fifo_word_serializer;
  localparam int MSBD  = 63;
  localparam int OUT_W = 16;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic [15:0] words_sent;
  int          tests_run    = 0;
  int          tests_failed = 0;

  fifo_word_serializer_if #(.MSBD(MSBD), .OUT_W(OUT_W)) bus ();

  fifo_word_serializer #(.MSBD(MSBD), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) dut (
    .clock      (clock),
    .rst        (rst),
    .bus        (bus.master),
    .words_sent (words_sent)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] fifo_q[$];
  logic [63:0] push_word = '0;
  logic [15:0] exp_words = '0;
  int          pop_cnt   = 0;
  int          valid_cnt = 0;
  logic        pop_seen  = 1'b0;
  logic        push_seen = 1'b0;
  logic        exp_pop;
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data = '0;
  logic        stall_last = 1'b0;
  beat_t       e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void refresh();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endfunction

  function automatic void expect_word(input logic [63:0] w);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.data = w[63 - 16*i -: 16];
      b.last = (i == 3);
      exp_q.push_back(b);
    end
  endfunction

  function automatic void preload(input logic [63:0] w);
    fifo_q.push_back(w);
    expect_word(w);
    refresh();
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((fifo_q.size() != 0 || bus.out_valid) && n < 100) begin
      tick();
      n++;
    end
    tests_run++;
    if (n >= 100) begin
      tests_failed++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, n);
    end
  endtask

  // rbFIFO model: pop/push decided mid-cycle, applied just after the edge
  always @(posedge clock) begin
    #1;
    if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (push_seen) fifo_q.push_back(push_word);
    refresh();
  end

  always @(negedge clock) begin
    pop_seen  = bus.fifo_pop;
    push_seen = bus.fifo_push_acc;
    exp_pop   = !rst && (!bus.out_valid || (bus.out_ready && bus.out_last))
                && !bus.fifo_empty && !bus.fifo_push_acc;
    check("fifo_pop", {63'd0, bus.fifo_pop}, {63'd0, exp_pop});
    if (bus.fifo_pop) pop_cnt++;
    if (bus.out_valid) valid_cnt++;
    check("words_sent", {48'd0, words_sent}, {48'd0, exp_words});
    if (stall_prev && !rst) begin
      check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
      check("stall_data", {48'd0, bus.out_data}, {48'd0, stall_data});
      check("stall_last", {63'd0, bus.out_last}, {63'd0, stall_last});
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL beat_extra: got beat %h, expected none", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", {48'd0, bus.out_data}, {48'd0, e.data});
        check("beat_last", {63'd0, bus.out_last}, {63'd0, e.last});
      end
      if (bus.out_last) exp_words = exp_words + 16'd1;
    end
    stall_prev = !rst && bus.out_valid && !bus.out_ready;
    stall_data = bus.out_data;
    stall_last = bus.out_last;
    if (rst) exp_words = '0;
  end

  initial begin
    int p0, v0, n;
    bus.out_ready     = 1'b1;
    bus.fifo_push_acc = 1'b0;
    refresh();

    // T1 reset with a word already waiting; T2 then streams that word
    preload(64'h0123_4567_89AB_CDEF);
    tick();
    tick();
    @(negedge clock);
    check("rst_pop", {63'd0, bus.fifo_pop}, 64'd0);
    check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_last", {63'd0, bus.out_last}, 64'd0);
    check("rst_data", {48'd0, bus.out_data}, 64'd0);
    check("rst_words", {48'd0, words_sent}, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clock);
    check("t2_pop", {63'd0, bus.fifo_pop}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t2_valid", {63'd0, bus.out_valid}, 64'd1);
    end
    @(negedge clock);
    check("t2_idle", {63'd0, bus.out_valid}, 64'd0);
    check("t2_words", {48'd0, words_sent}, 64'd1);

    // T3 back-to-back words
    tick();
    preload(64'h1111_2222_3333_4444);
    preload(64'hAAAA_BBBB_CCCC_DDDD);
    preload(64'h5A5A_A5A5_0F0F_F0F0);
    p0 = pop_cnt;
    v0 = valid_cnt;
    repeat (13) tick();
    check("t3_pops", 64'(pop_cnt - p0), 64'd3);
    check("t3_valid_run", 64'(valid_cnt - v0), 64'd12);
    wait_idle("t3_drain");
    check("t3_words", {48'd0, words_sent}, 64'd4);

    // T4 back-pressure on beat 2
    preload(64'hDEAD_BEEF_CAFE_F00D);
    tick();
    tick();
    tick();
    bus.out_ready = 1'b0;
    preload(64'h0001_0002_0003_0004);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t4_hold_data", {48'd0, bus.out_data}, 64'hCAFE);
      check("t4_no_pop", {63'd0, bus.fifo_pop}, 64'd0);
    end
    tick();
    bus.out_ready = 1'b1;
    wait_idle("t4_drain");
    check("t4_words", {48'd0, words_sent}, 64'd6);

    // T5 push collisions: idle load and last-beat reload
    tick();
    preload(64'h7777_8888_9999_AAAA);
    push_word = 64'hB0B1_B2B3_B4B5_B6B7;
    expect_word(push_word);
    bus.fifo_push_acc = 1'b1;
    @(negedge clock);
    check("t5_pop_blocked", {63'd0, bus.fifo_pop}, 64'd0);
    tick();
    bus.fifo_push_acc = 1'b0;
    @(negedge clock);
    check("t5_pop_retry", {63'd0, bus.fifo_pop}, 64'd1);
    tick();
    n = 0;
    while (!(bus.out_valid && bus.out_last) && n < 50) begin
      tick();
      n++;
    end
    check("t5_last_seen", {63'd0, bus.out_valid && bus.out_last}, 64'd1);
    push_word = 64'hC0C1_C2C3_C4C5_C6C7;
    expect_word(push_word);
    bus.fifo_push_acc = 1'b1;
    @(negedge clock);
    check("t5_reload_blocked", {63'd0, bus.fifo_pop}, 64'd0);
    tick();
    bus.fifo_push_acc = 1'b0;
    wait_idle("t5_drain");
    check("t5_words", {48'd0, words_sent}, 64'd9);

    // T6 reset after beat 1 of a word
    tick();
    preload(64'h1000_2000_3000_4000);
    preload(64'h5000_6000_7000_8000);
    tick();
    tick();
    tick();
    rst = 1'b1;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    tick();
    rst = 1'b0;
    @(negedge clock);
    check("t6_valid", {63'd0, bus.out_valid}, 64'd0);
    check("t6_words", {48'd0, words_sent}, 64'd0);
    check("t6_pop", {63'd0, bus.fifo_pop}, 64'd1);
    @(negedge clock);
    check("t6_beat0", {48'd0, bus.out_data}, 64'h5000);
    wait_idle("t6_drain");
    check("t6_words_end", {48'd0, words_sent}, 64'd1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
